gcd_stein: RTL
==============

# gcd_stein

Parametrised binary-GCD (Stein's algorithm) engine: the next generation of the team's GCD block. It computes gcd(a, b) for WIDTH-bit unsigned operands using only shifts, compares and subtracts, with no division. It sits between an upstream operand producer and a downstream consumer, using valid/ready handshakes on both sides so the consumer can apply backpressure. Zero operands are handled explicitly and flagged.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine idle and accepting; combinational decode of IDLE.
- a  in  WIDTH  operand A, sampled on acceptance.
- b  in  WIDTH  operand B, sampled on acceptance.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  gcd(a, b).
- zero  out  1  set with result when a==0 and b==0.
- cycles  out  16  compute-cycle count; present only with GCD_CYCLE_CNT_EN (see Configuration).

## Operation
- Internal registers: x, y (WIDTH bits each); k (shift count, $clog2(WIDTH) bits); state.
- States: IDLE, SHIFT, STEP, OUT.
- IDLE: in_ready=1. Acceptance occurs when in_valid && in_ready at a clock edge.
  - a==0 or b==0: result<=a|b, zero<=(a==0 && b==0), go to OUT.
  - Otherwise: x<=a, y<=b, k<=0, go to SHIFT.
- SHIFT, one decision per cycle:
  - x[0]==0 && y[0]==0: x<=x>>1, y<=y>>1, k<=k+1, stay.
  - Otherwise: no register change, go to STEP.
- STEP, first matching rule per cycle:
  1. x[0]==0: x<=x>>1.
  2. y[0]==0: y<=y>>1.
  3. x==y: result<=x<<k, zero<=0, go to OUT.
  4. x>y: x<=x-y.
  5. x<y: y<=y-x.
- OUT: out_valid=1. result and zero stay stable until out_valid && out_ready; then go to IDLE.
- Arithmetic: all arithmetic is unsigned and WIDTH-wide; subtraction never underflows by construction. x<<k cannot overflow because the true gcd is at most min(a,b).
- in_valid is ignored outside IDLE. There is no queuing; upstream must hold a and b until accepted.
- Reset, asynchronous, at any time including mid-computation: state=IDLE, x=y=0, k=0, result=0, zero=0, out_valid=0, cycles=0. in_ready reads 1 after reset. Any in-flight operation is discarded with no output.

## Timing
- Acceptance at edge T0 with a zero operand: out_valid=1 in the cycle after T0 (1-cycle latency).
- Nonzero operands: latency = 1 (enter SHIFT) + n_shift + 1 (SHIFT→STEP) + n_step, where the final STEP cycle is the x==y cycle. out_valid rises the cycle after that final STEP cycle.
- Worst-case latency is bounded by about 4*WIDTH+2 cycles. No timeout is applied.
- out_valid with out_ready=1 on the same cycle: handoff completes at that edge and in_ready=1 the next cycle. Minimum back-to-back throughput is one result per (latency+1) cycles.
- out_valid never drops without a handshake, except on reset.

## Configuration
- GCD_CYCLE_CNT_EN defined:
  - Adds output cycles[15:0].
  - Cleared to 0 on acceptance.
  - Increments by 1 on every SHIFT and STEP cycle, saturating at 16'hFFFF.
  - Valid and stable while out_valid=1; reads 0 for zero-operand results.
- GCD_CYCLE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: rst asserted mid-computation of (48,18) → in the next cycle out_valid=0, result=0, in_ready=1. A fresh (48,18) then yields 6.
- (12,18) accepted at T0 → SHIFT 1 cycle (k=1), SHIFT→STEP 1 cycle, STEP 4 cycles. out_valid=1 at T0+7 with result=6, zero=0; cycles=6 with GCD_CYCLE_CNT_EN.
- Zero cases:
  - (0,5) → out_valid at T0+1, result=5, zero=0.
  - (0,0) → result=0, zero=1.
  - (7,0) → result=7.
- Backpressure: (1071,462) with out_ready held 0 for 10 cycles → result=21 stays stable with out_valid=1 throughout. in_ready stays 0, and in_valid pulses during this time are ignored.
- Extremes, WIDTH=32:
  - (32'hFFFFFFFF, 32'hFFFFFFFF) → result 32'hFFFFFFFF.
  - (32'h80000000, 32'h40000000) → result 32'h40000000.
  - (32'hFFFFFFFB, 2) → result 1.
- Back-to-back random pairs at WIDTH=8 and WIDTH=64, with out_ready tied high → every result matches the reference model gcd, and in_ready reasserts exactly one cycle after each handoff.

Source files
------------

// File: rtl/gcd_stein_if.sv
// Valid/ready operand and result channel for the gcd_stein binary-GCD engine.
// The cycles member exists only when GCD_CYCLE_CNT_EN is defined.
interface gcd_stein_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef GCD_CYCLE_CNT_EN
    logic [15:0]      cycles;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, zero, cycles);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, zero, cycles);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, zero);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, zero);
`endif
endinterface

// File: rtl/gcd_stein.sv
// Binary GCD (Stein) engine with valid/ready on both sides and explicit zero-operand handling.
// Optional compute-cycle counter output enabled by defining GCD_CYCLE_CNT_EN.
module gcd_stein #(
    parameter int WIDTH = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    gcd_stein_if.slave s_io
);
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_STEP,
        S_OUT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;
`ifdef GCD_CYCLE_CNT_EN
    logic [15:0]      r_cycles;
`endif

    // NOTE: all state below is updated with <= so every branch reads the pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_k         <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef GCD_CYCLE_CNT_EN
            r_cycles    <= '0;
`endif
        end else begin
`ifdef GCD_CYCLE_CNT_EN
            if (r_state == S_IDLE && s_io.in_valid)
                r_cycles <= '0;
            else if ((r_state == S_SHIFT || r_state == S_STEP) && r_cycles != 16'hFFFF)
                r_cycles <= r_cycles + 16'd1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (s_io.in_valid) begin
                        if (s_io.a == '0 || s_io.b == '0) begin
                            r_result    <= s_io.a | s_io.b;
                            r_zero      <= (s_io.a == '0) && (s_io.b == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_x     <= s_io.a;
                            r_y     <= s_io.b;
                            r_k     <= '0;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                // Strip the common power of two; k remembers how much to restore.
                S_SHIFT: begin
                    if (!r_x[0] && !r_y[0]) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + KW'(1);
                    end else begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x == r_y) begin
                        r_result    <= r_x << r_k;
                        r_zero      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (r_x > r_y) begin
                        r_x <= r_x - r_y;
                    end else begin
                        r_y <= r_y - r_x;
                    end
                end
                S_OUT: begin
                    if (s_io.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_io.in_ready  = (r_state == S_IDLE);
    assign s_io.out_valid = r_out_valid;
    assign s_io.result    = r_result;
    assign s_io.zero      = r_zero;
`ifdef GCD_CYCLE_CNT_EN
    assign s_io.cycles    = r_cycles;
`endif
endmodule
